// File: rtl/md_pkg.sv
// Shared MD op codes and default latencies for the HI/LO multiply/divide unit.
// Used by the CU decode and by the sequencer and its arithmetic core.
// No logic, no latency, no backpressure.
package md_pkg;

    typedef enum logic [3:0] {
        MD_NONE  = 4'd0,
        MD_MULT  = 4'd1,
        MD_MULTU = 4'd2,
        MD_DIV   = 4'd3,
        MD_DIVU  = 4'd4,
        MD_MFHI  = 4'd5,
        MD_MFLO  = 4'd6,
        MD_MTHI  = 4'd7,
        MD_MTLO  = 4'd8
    } md_op_t;

    localparam int MD_MULT_CYCLES = 5;
    localparam int MD_DIV_CYCLES  = 10;

    // True for any of the eight ops that use the shared HI/LO resource.
    function automatic logic md_is_md(input md_op_t op);
        return (op >= MD_MULT) && (op <= MD_MTLO);
    endfunction

    // True for the ops that start a multi-cycle computation.
    function automatic logic md_is_arith(input md_op_t op);
        return (op >= MD_MULT) && (op <= MD_DIVU);
    endfunction

endpackage

// File: rtl/md_sequencer_if.sv
// E-stage request, D-stage hazard query and HI/LO result signals of the MD unit.
// Pure wiring, no latency.
// Backpressure is stall_req, which holds an MD op in D while busy.
interface md_sequencer_if;
    import md_pkg::*;

    md_op_t      e_op;
    logic        e_valid;
    logic [31:0] e_a;
    logic [31:0] e_b;
    logic        d_is_md;
    logic        busy;
    logic        stall_req;
    logic [31:0] md_rdata;
    logic [31:0] hi;
    logic [31:0] lo;

    // Pipeline side: issues ops and consumes stall/read data.
    modport master (
        output e_op, e_valid, e_a, e_b, d_is_md,
        input  busy, stall_req, md_rdata, hi, lo
    );

    // MD unit side.
    modport slave (
        input  e_op, e_valid, e_a, e_b, d_is_md,
        output busy, stall_req, md_rdata, hi, lo
    );

endinterface

// File: rtl/md_arith.sv
// Combinational multiply/divide core producing HI/LO results and a divide-by-zero flag.
// Zero latency; the sequencer models the architectural delay.
// No backpressure.
module md_arith
    import md_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  md_op_t      op,
    output logic [31:0] hi_res,
    output logic [31:0] lo_res,
    output logic        div0
);

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] divisor;
    logic [31:0] quo;
    logic [31:0] rem;

    // Signed product via explicit sign extension; low 64 bits are exact.
    assign prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    assign prod_u = {32'd0, a} * {32'd0, b};

    // Divide on magnitudes so INT_MIN / -1 wraps to INT_MIN instead of trapping.
    assign a_neg   = (op == MD_DIV) && a[31];
    assign b_neg   = (op == MD_DIV) && b[31];
    assign a_mag   = a_neg ? (~a + 32'd1) : a;
    assign b_mag   = b_neg ? (~b + 32'd1) : b;
    assign divisor = (b_mag == 32'd0) ? 32'd1 : b_mag;
    assign quo     = a_mag / divisor;
    assign rem     = a_mag % divisor;

    // Select the result pair for the requested op.
    always_comb begin
        hi_res = 32'd0;
        lo_res = 32'd0;
        div0   = 1'b0;
        case (op)
            MD_MULT:  {hi_res, lo_res} = prod_s;
            MD_MULTU: {hi_res, lo_res} = prod_u;
            MD_DIV, MD_DIVU: begin
                lo_res = (a_neg ^ b_neg) ? (~quo + 32'd1) : quo;
                hi_res = a_neg ? (~rem + 32'd1) : rem;
                div0   = (b == 32'd0);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/md_sequencer.sv
// Sequences the shared HI/LO mult/div unit: issues, counts down latency, commits HI/LO.
// mult commits MULT_CYCLES edges after issue, div after DIV_CYCLES; mfhi/mflo read is combinational.
// Backpressure: stall_req holds an MD-class D-stage op while busy.
module md_sequencer
    import md_pkg::*;
#(
    parameter int MULT_CYCLES = MD_MULT_CYCLES,
    parameter int DIV_CYCLES  = MD_DIV_CYCLES
) (
    input  logic          clk,
    input  logic          reset_n,
    md_sequencer_if.slave md
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    logic [CW-1:0] cnt;
    logic [31:0]   hi_q;
    logic [31:0]   lo_q;
    logic [31:0]   hi_nxt;
    logic [31:0]   lo_nxt;
    logic          commit_en;
    logic [31:0]   hi_res;
    logic [31:0]   lo_res;
    logic          div0;
    logic          issue;
    logic          is_mult;

    md_arith u_arith (
        .a      (md.e_a),
        .b      (md.e_b),
        .op     (md.e_op),
        .hi_res (hi_res),
        .lo_res (lo_res),
        .div0   (div0)
    );

    assign issue   = md.e_valid && md_is_arith(md.e_op) && (cnt == '0);
    assign is_mult = (md.e_op == MD_MULT) || (md.e_op == MD_MULTU);

    assign md.busy      = (cnt != '0) || issue;
    assign md.stall_req = md.d_is_md && md.busy;
    assign md.hi        = hi_q;
    assign md.lo        = lo_q;

    // Read port: committed HI/LO only, gated by a live mfhi/mflo.
    always_comb begin
        md.md_rdata = 32'd0;
        if (md.e_valid && (md.e_op == MD_MFHI)) md.md_rdata = hi_q;
        if (md.e_valid && (md.e_op == MD_MFLO)) md.md_rdata = lo_q;
    end

    // Issue latches the pending result, the counter models latency, commit lands on 1->0.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt       <= '0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            hi_nxt    <= 32'd0;
            lo_nxt    <= 32'd0;
            commit_en <= 1'b0;
        end else if (issue) begin
            cnt       <= is_mult ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
            hi_nxt    <= hi_res;
            lo_nxt    <= lo_res;
            commit_en <= !div0;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
            if ((cnt == CW'(1)) && commit_en) begin
                hi_q <= hi_nxt;
                lo_q <= lo_nxt;
            end
        end else if (md.e_valid && (md.e_op == MD_MTHI)) begin
            hi_q <= md.e_a;
        end else if (md.e_valid && (md.e_op == MD_MTLO)) begin
            lo_q <= md.e_a;
        end
    end

    // Hazard logic must keep MD ops out of E while the counter runs.
    a_no_md_while_busy: assert property (@(posedge clk) disable iff (!reset_n)
        !(md.e_valid && md_is_md(md.e_op) && (cnt != '0)));

endmodule

// File: tb/tb_md_sequencer.sv
// Directed bench for md_sequencer with hand-computed HI/LO results and busy timing.
// Inputs change 1ns after the rising edge; outputs are sampled there too.
// Every wait on busy is bounded.
module tb_md_sequencer;
    import md_pkg::*;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    md_sequencer_if md_if ();

    md_sequencer #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .md      (md_if.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        md_if.e_valid = 1'b0;
        md_if.e_op    = MD_NONE;
        md_if.e_a     = 32'd0;
        md_if.e_b     = 32'd0;
    endtask

    // Present one op in E for one cycle, then return E to a bubble.
    task automatic send(input md_op_t op, input logic [31:0] a, input logic [31:0] b);
        md_if.e_valid = 1'b1;
        md_if.e_op    = op;
        md_if.e_a     = a;
        md_if.e_b     = b;
        tick();
        idle_in();
    endtask

    // Count post-issue cycles with busy high, bounded at 50.
    task automatic wait_busy(output int n);
        n = 0;
        while (md_if.busy && n < 50) begin
            n++;
            tick();
        end
    endtask

    int n;
    int stall_cnt;
    int stall_bad;

    initial begin
        idle_in();
        md_if.d_is_md = 1'b0;
        #12;
        check("rst_busy",  32'(md_if.busy), 32'd0);
        check("rst_stall", 32'(md_if.stall_req), 32'd0);
        check("rst_hi",    md_if.hi, 32'd0);
        check("rst_lo",    md_if.lo, 32'd0);
        check("rst_rdata", md_if.md_rdata, 32'd0);
        reset_n = 1'b1;
        tick();

        // 1: reset in the middle of a MULT aborts it and clears HI/LO
        send(MD_MTHI, 32'h55, 32'd0);
        check("mthi_55", md_if.hi, 32'h55);
        send(MD_MULT, 32'd3, 32'd4);
        tick();
        reset_n = 1'b0;
        #1;
        check("midrst_busy", 32'(md_if.busy), 32'd0);
        check("midrst_hi",   md_if.hi, 32'd0);
        check("midrst_lo",   md_if.lo, 32'd0);
        tick();
        reset_n = 1'b1;
        repeat (8) tick();
        check("postrst_busy", 32'(md_if.busy), 32'd0);
        check("postrst_lo",   md_if.lo, 32'd0);
        check("postrst_hi",   md_if.hi, 32'd0);

        // 2: signed and unsigned multiply of 0xFFFFFFFF * 2
        md_if.e_valid = 1'b1;
        md_if.e_op    = MD_MULT;
        md_if.e_a     = 32'hFFFF_FFFF;
        md_if.e_b     = 32'd2;
        #1;
        check("mult_issue_busy", 32'(md_if.busy), 32'd1);
        tick();
        idle_in();
        check("mult_hi_pending", md_if.hi, 32'd0);
        wait_busy(n);
        check("mult_cycles", 32'(n), 32'd5);
        check("mult_hi", md_if.hi, 32'hFFFF_FFFF);
        check("mult_lo", md_if.lo, 32'hFFFF_FFFE);
        send(MD_MULTU, 32'hFFFF_FFFF, 32'd2);
        wait_busy(n);
        check("multu_cycles", 32'(n), 32'd5);
        check("multu_hi", md_if.hi, 32'd1);
        check("multu_lo", md_if.lo, 32'hFFFF_FFFE);

        // 3: signed divide, including the overflow corner
        send(MD_DIV, 32'hFFFF_FFF9, 32'd2);
        wait_busy(n);
        check("div_cycles", 32'(n), 32'd10);
        check("div_lo", md_if.lo, 32'hFFFF_FFFD);
        check("div_hi", md_if.hi, 32'hFFFF_FFFF);
        send(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_busy(n);
        check("divovf_lo", md_if.lo, 32'h8000_0000);
        check("divovf_hi", md_if.hi, 32'd0);
        send(MD_DIVU, 32'd100, 32'd7);
        wait_busy(n);
        check("divu_lo", md_if.lo, 32'd14);
        check("divu_hi", md_if.hi, 32'd2);

        // 4: divide by zero keeps timing but leaves HI/LO untouched
        send(MD_MTHI, 32'h1234, 32'd0);
        check("mthi_busy", 32'(md_if.busy), 32'd0);
        send(MD_MTLO, 32'h5678, 32'd0);
        send(MD_DIVU, 32'd5, 32'd0);
        wait_busy(n);
        check("div0_cycles", 32'(n), 32'd10);
        check("div0_hi", md_if.hi, 32'h1234);
        check("div0_lo", md_if.lo, 32'h5678);

        // 5: MFLO waiting in D stalls exactly while busy, then reads the new LO
        md_if.d_is_md = 1'b1;
        md_if.e_valid = 1'b1;
        md_if.e_op    = MD_MULT;
        md_if.e_a     = 32'd6;
        md_if.e_b     = 32'd7;
        #1;
        check("stall_issue", 32'(md_if.stall_req), 32'd1);
        tick();
        idle_in();
        stall_cnt = 0;
        stall_bad = 0;
        while (md_if.stall_req && stall_cnt < 50) begin
            if (md_if.stall_req !== md_if.busy) stall_bad++;
            stall_cnt++;
            tick();
        end
        check("stall_cycles", 32'(stall_cnt), 32'd5);
        check("stall_eq_busy", 32'(stall_bad), 32'd0);
        md_if.d_is_md = 1'b0;
        md_if.e_valid = 1'b1;
        md_if.e_op    = MD_MFLO;
        #1;
        check("mflo_after_mult", md_if.md_rdata, 32'd42);
        tick();
        idle_in();

        // 6: MTLO then MFLO back to back, and a non-valid MULT is ignored
        send(MD_MTLO, 32'hABCD, 32'd0);
        md_if.e_valid = 1'b1;
        md_if.e_op    = MD_MFLO;
        #1;
        check("mflo_rdata", md_if.md_rdata, 32'hABCD);
        check("mflo_busy",  32'(md_if.busy), 32'd0);
        md_if.e_op = MD_MFHI;
        #1;
        check("mfhi_rdata", md_if.md_rdata, 32'd0);
        tick();
        md_if.e_valid = 1'b0;
        md_if.e_op    = MD_MULT;
        md_if.e_a     = 32'd9;
        md_if.e_b     = 32'd9;
        #1;
        check("inval_busy",  32'(md_if.busy), 32'd0);
        check("inval_rdata", md_if.md_rdata, 32'd0);
        tick();
        tick();
        check("inval_busy2", 32'(md_if.busy), 32'd0);
        check("inval_lo",    md_if.lo, 32'hABCD);
        check("inval_hi",    md_if.hi, 32'd0);
        idle_in();
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
